// File: rtl/barrel_scheduler.sv
// Barrel throw scheduler: paces Donkey Kong's throws per frame, allocates each
// new barrel to the lowest free motion slot, and freezes spawning on a player hit.
module barrel_scheduler #(
  parameter int         NUM_SLOTS    = 4,
  parameter int         SPAWN_PERIOD = 120,
  parameter int         THROW_FRAMES = 16,
  parameter logic [9:0] SPAWN_X      = 10'd100,
  parameter logic [9:0] SPAWN_Y      = 10'd114
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic                         enable,
  input  logic                         hit,
  input  logic [NUM_SLOTS-1:0]         retire,
  output logic                         spawn_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
  output logic [9:0]                   spawn_X,
  output logic [9:0]                   spawn_Y,
  output logic [NUM_SLOTS-1:0]         slot_active,
  output logic                         throw_anim,
  output logic                         frozen,
  output logic [7:0]                   spawned_total
);

  localparam int SLOT_W  = $clog2(NUM_SLOTS);
  localparam int CNT_MAX = (SPAWN_PERIOD > THROW_FRAMES) ? SPAWN_PERIOD : THROW_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [CNT_W-1:0] THROW_LAST = CNT_W'(THROW_FRAMES - 1);

  typedef enum logic [2:0] {IDLE, COUNT, THROW, SPAWN, FROZEN} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  spawn_valid_d;
  logic [SLOT_W-1:0]     spawn_slot_d;
  logic [NUM_SLOTS-1:0]  slot_active_d;
  logic [7:0]            spawned_total_d;

  function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOTS-1:0] mask);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!mask[i]) idx = SLOT_W'(i);
    return idx;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign spawn_X = SPAWN_X;
  assign spawn_Y = SPAWN_Y;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    spawn_valid_d   = 1'b0;
    spawn_slot_d    = spawn_slot;
    slot_active_d   = slot_active & ~retire;
    spawned_total_d = spawned_total;

    if (hit || state_q == FROZEN) begin
      state_d = FROZEN;
    end else if (!enable) begin
      state_d       = IDLE;
      cnt_d         = '0;
      slot_active_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = COUNT;
          cnt_d   = '0;
        end
        COUNT: begin
          // Free-slot test uses the registered mask, so a same-edge retire waits a frame.
          if (cnt_q == COUNT_LAST) begin
            if (!(&slot_active)) begin
              state_d = THROW;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        THROW: begin
          if (cnt_q == THROW_LAST) begin
            state_d         = SPAWN;
            cnt_d           = '0;
            spawn_valid_d   = 1'b1;
            spawn_slot_d    = lowest_free(slot_active);
            slot_active_d   = slot_active_d | (NUM_SLOTS'(1) << spawn_slot_d);
            spawned_total_d = sat_inc8(spawned_total);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SPAWN: begin
          state_d = COUNT;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      spawn_valid   <= 1'b0;
      spawn_slot    <= '0;
      slot_active   <= '0;
      throw_anim    <= 1'b0;
      frozen        <= 1'b0;
      spawned_total <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      spawn_valid   <= spawn_valid_d;
      spawn_slot    <= spawn_slot_d;
      slot_active   <= slot_active_d;
      throw_anim    <= (state_d == THROW);
      frozen        <= (state_d == FROZEN);
      spawned_total <= spawned_total_d;
    end
  end

endmodule

// File: tb/tb_barrel_scheduler.sv
// Bench for barrel_scheduler: timeline-based reference model with per-cycle compare,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_barrel_scheduler;

  localparam int NS = 4;
  localparam int SP = 4;
  localparam int TF = 2;

  logic          frame_clk = 1'b0;
  logic          Reset     = 1'b0;
  logic          enable    = 1'b0;
  logic          hit       = 1'b0;
  logic [NS-1:0] retire    = '0;
  logic          spawn_valid;
  logic [1:0]    spawn_slot;
  logic [9:0]    spawn_X, spawn_Y;
  logic [NS-1:0] slot_active;
  logic          throw_anim, frozen;
  logic [7:0]    spawned_total;

  int n_vec = 0;
  int n_err = 0;

  barrel_scheduler #(
    .NUM_SLOTS(NS), .SPAWN_PERIOD(SP), .THROW_FRAMES(TF),
    .SPAWN_X(10'd100), .SPAWN_Y(10'd114)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .hit(hit), .retire(retire),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_X(spawn_X), .spawn_Y(spawn_Y),
    .slot_active(slot_active), .throw_anim(throw_anim), .frozen(frozen),
    .spawned_total(spawned_total)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference model: time since cycle start and the moment the throw began.
  bit            m_running  = 1'b0;
  bit            m_frozen   = 1'b0;
  bit            m_spawn    = 1'b0;
  int            m_since    = 0;
  int            m_throw_at = -1;
  int            m_slot     = 0;
  int            m_total    = 0;
  logic [NS-1:0] m_mask     = '0;

  task automatic m_reset();
    m_running = 1'b0; m_frozen = 1'b0; m_spawn = 1'b0;
    m_since = 0; m_throw_at = -1; m_slot = 0; m_total = 0; m_mask = '0;
  endtask

  task automatic m_edge();
    logic [NS-1:0] pre;
    bit was_spawn;
    int s;
    pre = m_mask;
    was_spawn = m_spawn;
    m_spawn = 1'b0;
    if (m_frozen || hit) begin
      m_frozen = 1'b1;
      m_mask = pre & ~retire;
    end else if (!enable) begin
      m_running = 1'b0;
      m_mask = '0;
    end else if (!m_running) begin
      m_running = 1'b1; m_since = 0; m_throw_at = -1;
      m_mask = pre & ~retire;
    end else begin
      m_mask = pre & ~retire;
      if (was_spawn) begin
        m_since = 0; m_throw_at = -1;
      end else if (m_throw_at < 0) begin
        if (m_since >= SP - 1 && pre != {NS{1'b1}}) m_throw_at = m_since + 1;
        m_since++;
      end else begin
        if (m_since - m_throw_at == TF - 1) begin
          s = -1;
          for (int i = 0; i < NS; i++) if (!pre[i] && s < 0) s = i;
          m_slot = s;
          m_mask[s] = 1'b1;
          m_spawn = 1'b1;
          if (m_total < 255) m_total++;
        end
        m_since++;
      end
    end
  endtask

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) m_reset();
    else m_edge();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge frame_clk) begin
    chk("spawn_valid", 32'(spawn_valid), 32'(m_spawn));
    chk("spawn_slot", 32'(spawn_slot), 32'(m_slot));
    chk("slot_active", 32'(slot_active), 32'(m_mask));
    chk("throw_anim", 32'(throw_anim),
        32'(m_running && !m_frozen && m_throw_at >= 0 && !m_spawn));
    chk("frozen", 32'(frozen), 32'(m_frozen));
    chk("spawned_total", 32'(spawned_total), 32'(m_total));
    chk("spawn_X", 32'(spawn_X), 32'd100);
    chk("spawn_Y", 32'(spawn_Y), 32'd114);
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0; hit = 1'b0; retire = '0;
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
  endtask

  int waits;
  int spawns;

  initial begin
    // Reset state
    do_reset();
    chk("rst spawn_valid", 32'(spawn_valid), 0);
    chk("rst slot_active", 32'(slot_active), 0);
    chk("rst total", 32'(spawned_total), 0);
    chk("rst frozen", 32'(frozen), 0);

    // Basic spawn timing, then async reset in the middle of a throw
    enable = 1'b1;
    tick();                       // edge 0
    repeat (4) tick();            // edge 4
    chk("basic throw e4", 32'(throw_anim), 1);
    tick();                       // edge 5
    chk("basic throw e5", 32'(throw_anim), 1);
    chk("basic no spawn e5", 32'(spawn_valid), 0);
    tick();                       // edge 6
    chk("basic spawn e6", 32'(spawn_valid), 1);
    chk("basic slot e6", 32'(spawn_slot), 0);
    chk("basic mask e6", 32'(slot_active), 32'b0001);
    chk("basic total e6", 32'(spawned_total), 1);
    chk("basic anim e6", 32'(throw_anim), 0);
    tick();                       // edge 7
    chk("basic pulse e7", 32'(spawn_valid), 0);
    repeat (6) tick();            // edge 13
    chk("basic spawn e13", 32'(spawn_valid), 1);
    chk("basic slot e13", 32'(spawn_slot), 1);
    chk("basic mask e13", 32'(slot_active), 32'b0011);
    repeat (5) tick();            // edge 18
    chk("throw before reset", 32'(throw_anim), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async rst anim", 32'(throw_anim), 0);
    chk("async rst mask", 32'(slot_active), 0);
    chk("async rst total", 32'(spawned_total), 0);
    chk("async rst slot", 32'(spawn_slot), 0);
    tick();
    Reset = 1'b0; enable = 1'b0;

    // Same-edge retire and allocation, then full pool
    do_reset();
    enable = 1'b1;
    tick();                       // edge 0
    repeat (26) tick();           // edge 26
    chk("pre-same mask", 32'(slot_active), 32'b0111);
    chk("pre-same anim", 32'(throw_anim), 1);
    retire = 4'b0001;
    tick();                       // edge 27
    retire = '0;
    chk("same spawn", 32'(spawn_valid), 1);
    chk("same slot", 32'(spawn_slot), 3);
    chk("same mask", 32'(slot_active), 32'b1110);
    chk("same total", 32'(spawned_total), 4);
    repeat (7) tick();            // edge 34
    chk("fill slot", 32'(spawn_slot), 0);
    chk("fill mask", 32'(slot_active), 32'b1111);
    repeat (12) tick();
    chk("full no spawn", 32'(spawn_valid), 0);
    chk("full no anim", 32'(throw_anim), 0);
    retire = 4'b0100;
    tick();
    retire = '0;
    chk("retire clears", 32'(slot_active), 32'b1011);
    waits = 0;
    while (!spawn_valid && waits < 12) begin tick(); waits++; end
    chk("refill latency", 32'(waits), 3);
    chk("refill slot", 32'(spawn_slot), 2);
    chk("refill mask", 32'(slot_active), 32'b1111);

    // Hit during throw freezes until reset
    do_reset();
    enable = 1'b1;
    tick();
    repeat (4) tick();            // edge 4, throwing
    hit = 1'b1;
    tick();
    hit = 1'b0;
    chk("hit frozen", 32'(frozen), 1);
    chk("hit anim", 32'(throw_anim), 0);
    spawns = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) enable = 1'b0;
      tick();
      if (spawn_valid) spawns++;
    end
    chk("frozen spawns", 32'(spawns), 0);
    chk("frozen after disable", 32'(frozen), 1);

    // Disable during COUNT clears the pool and restarts timing
    do_reset();
    enable = 1'b1;
    tick();
    repeat (15) tick();           // edge 15, counting
    chk("dis mask before", 32'(slot_active), 32'b0011);
    enable = 1'b0;
    tick();
    chk("dis mask", 32'(slot_active), 0);
    chk("dis anim", 32'(throw_anim), 0);
    tick();
    enable = 1'b1;
    tick();                       // new edge 0
    repeat (5) tick();            // edge 5
    chk("re-en no spawn", 32'(spawn_valid), 0);
    chk("re-en anim", 32'(throw_anim), 1);
    tick();                       // edge 6
    chk("re-en spawn", 32'(spawn_valid), 1);
    chk("re-en slot", 32'(spawn_slot), 0);
    chk("re-en mask", 32'(slot_active), 32'b0001);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom % 32) != 0;
      hit    = ($urandom % 600) == 0;
      for (int b = 0; b < NS; b++) retire[b] = ($urandom % 6) == 0;
      if (($urandom % 400) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
      tick();
    end
    enable = 1'b0; hit = 1'b0; retire = '0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
